// File: rtl/minv_mdiv_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | minv_mdiv_engine                                                           |
// | Binary extended-Euclid engine: a^-1 mod p (mode=1) or b*a^-1 mod p (mode=0)|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module minv_mdiv_engine #(
  parameter int WIDTH = 256,
  parameter int CNT_W = $clog2(4*WIDTH)+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_LOOP  = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_THREE      = WIDTH'(3);
  localparam logic [CNT_W-1:0] C_ITER_LIMIT = CNT_W'(4*WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] r_v;
  logic [WIDTH-1:0] r_x1;
  logic [WIDTH-1:0] r_x2;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_iter;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [WIDTH-1:0] w_x1_half;
  logic [WIDTH-1:0] w_x2_half;
  logic [WIDTH-1:0] w_x1_sub;
  logic [WIDTH-1:0] w_x2_sub;
  logic             w_param_bad;
  logic             w_accept;

  // For odd x and odd p, (x+p)/2 = x/2 + p/2 + 1 exactly, and stays below p,
  // so the halving never needs a carry bit.
  always_comb begin
    w_x1_half = r_x1 >> 1;
    w_x2_half = r_x2 >> 1;
    if (r_x1[0]) begin
      w_x1_half = (r_x1 >> 1) + (r_p >> 1) + C_ONE;
    end
    if (r_x2[0]) begin
      w_x2_half = (r_x2 >> 1) + (r_p >> 1) + C_ONE;
    end
  end

  // Modular subtraction: when the raw difference would go negative, p - (y - x)
  // gives the wrapped value without leaving [0,p).
  always_comb begin
    w_x1_sub = r_x1 - r_x2;
    w_x2_sub = r_x2 - r_x1;
    if (r_x1 < r_x2) begin
      w_x1_sub = r_p - (r_x2 - r_x1);
    end
    if (r_x2 < r_x1) begin
      w_x2_sub = r_p - (r_x1 - r_x2);
    end
  end

  // x1 holds b (or 1 in inversion mode), so one compare covers the b>=p check.
  always_comb begin
    w_param_bad = !r_p[0] || (r_p < C_THREE) || (r_u == '0) ||
                  (r_u >= r_p) || (r_x1 >= r_p);
    w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_u      <= '0;
      r_v      <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_p      <= '0;
      r_result <= '0;
      r_iter   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_u      <= a;
        r_v      <= p;
        r_x1     <= mode ? C_ONE : b;
        r_x2     <= '0;
        r_p      <= p;
        r_iter   <= '0;
        r_err    <= 1'b0;
        r_result <= '0;
        r_busy   <= 1'b1;
        r_state  <= S_CHECK;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
          end
          S_CHECK: begin
            if (w_param_bad) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_LOOP;
            end
          end
          S_LOOP: begin
            if ((r_u == C_ONE) || (r_v == C_ONE)) begin
              r_state <= S_FINAL;
            end else if ((r_u == '0) || (r_v == '0) || (r_iter == C_ITER_LIMIT)) begin
              // Zero operand means gcd(a,p) > 1; the limit guards against non-convergence.
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_iter <= r_iter + C_CNT_ONE;
              if (!r_u[0]) begin
                r_u  <= r_u >> 1;
                r_x1 <= w_x1_half;
              end else if (!r_v[0]) begin
                r_v  <= r_v >> 1;
                r_x2 <= w_x2_half;
              end else if (r_u >= r_v) begin
                r_u  <= r_u - r_v;
                r_x1 <= w_x1_sub;
              end else begin
                r_v  <= r_v - r_u;
                r_x2 <= w_x2_sub;
              end
            end
          end
          S_FINAL: begin
            r_result <= (r_u == C_ONE) ? r_x1 : r_x2;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign result   = r_result;
  assign iter_cnt = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_minv_mdiv_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_minv_mdiv_engine                                                        |
// | Scoreboard bench for minv_mdiv_engine at WIDTH=8 with directed vectors     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_minv_mdiv_engine;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(4*WIDTH)+1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] iter_cnt;

  typedef struct {
    int res;
    int err;
    int iter;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_done   = 0;
  int   cyc      = 0;
  int   st_cyc   = 0;

  minv_mdiv_engine #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .p        (p),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .iter_cnt (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        chk("result", int'(result), e.res);
        chk("err", int'(err), e.err);
        if (e.iter >= 0) chk("iter_cnt", int'(iter_cnt), e.iter);
        if (e.lat >= 0) chk("latency", cyc - st_cyc + 1, e.lat);
      end
      n_done++;
    end
  end

  task automatic run_op(input logic m, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                        input logic [WIDTH-1:0] pp, input int er, input int ee,
                        input int it, input int lt, input bit poke);
    exp_t e;
    int   n0;
    e.res = er; e.err = ee; e.iter = it; e.lat = lt;
    sb_q.push_back(e);
    n0 = n_done;
    @(negedge clk);
    mode = m; a = aa; b = bb; p = pp; start = 1'b1;
    @(posedge clk);
    #1;
    st_cyc = cyc;
    start  = 1'b0;
    if (poke) begin
      @(negedge clk);
      @(negedge clk);
      chk("busy_at_poke", int'(busy), 1);
      mode = ~m; a = 8'd1; b = 8'd2; p = 8'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0; mode = m; a = aa; b = bb; p = pp;
    end
    for (int k = 0; k < 200 && n_done == n0; k++) @(negedge clk);
    if (n_done == n0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: actual=no_done required=done (t=%0t)", $time);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_err"}, int'(err), 0);
    chk({nm, "_result"}, int'(result), 0);
    chk({nm, "_iter"}, int'(iter_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0; p = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b1;
    @(negedge clk);

    //      mode  a       b       p       res  err iter lat poke
    run_op(1'b1, 8'd3,   8'd0,   8'd7,   5,   0,  3,   7,  1'b0);
    run_op(1'b0, 8'd3,   8'd5,   8'd11,  9,   0,  4,   8,  1'b0);
    run_op(1'b1, 8'd1,   8'd0,   8'd7,   1,   0,  0,   4,  1'b0);
    run_op(1'b1, 8'd0,   8'd0,   8'd7,   0,   1,  0,   2,  1'b0);
    run_op(1'b1, 8'd3,   8'd0,   8'd8,   0,   1,  0,   2,  1'b0);
    run_op(1'b1, 8'd7,   8'd0,   8'd7,   0,   1,  0,   2,  1'b0);
    run_op(1'b1, 8'd255, 8'd0,   8'd251, 0,   1,  0,   2,  1'b0);
    run_op(1'b1, 8'd3,   8'd0,   8'd9,   0,   1,  3,   6,  1'b0);
    run_op(1'b0, 8'd3,   8'd7,   8'd7,   0,   1,  0,   2,  1'b0);
    run_op(1'b1, 8'd2,   8'd0,   8'd13,  7,   0,  1,   5,  1'b0);
    run_op(1'b1, 8'd2,   8'd0,   8'd3,   2,   0,  1,   5,  1'b0);
    run_op(1'b0, 8'd2,   8'd3,   8'd13,  8,   0,  1,   5,  1'b0);
    run_op(1'b1, 8'd3,   8'd200, 8'd7,   5,   0,  3,   7,  1'b1);
    run_op(1'b1, 8'd250, 8'd0,   8'd251, 250, 0,  11,  15, 1'b0);
    run_op(1'b0, 8'd250, 8'd2,   8'd251, 249, 0,  11,  15, 1'b0);
    run_op(1'b0, 8'd5,   8'd0,   8'd251, 0,   0,  -1,  -1, 1'b0);

    // Reset while idle must clear the held result.
    run_op(1'b1, 8'd3, 8'd0, 8'd7, 5, 0, 3, 7, 1'b0);
    rst = 1'b0;
    #1;
    chk_zero("idle_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset mid-LOOP: the aborted run must never pulse done.
    mode = 1'b0; a = 8'd3; b = 8'd5; p = 8'd11; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk_zero("loop_reset");
    repeat (2) @(negedge clk);
    chk_zero("held_reset");
    rst = 1'b1;
    repeat (20) @(negedge clk);
    run_op(1'b0, 8'd3, 8'd5, 8'd11, 9, 0, 4, 8, 1'b0);

    repeat (5) @(negedge clk);
    chk("leftover_expectations", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
